inst_fetch_unit: RTL and testbench
==================================

Name: inst_fetch_unit

Overview:
- Upstream neighbour of the control unit: owns the program counter and the instruction register.
- On each fetch request it issues a word read to instruction memory, waits a variable number of cycles for completion, and latches the returned word on the INSTRUCTION bus.
- Applies the next-PC update (sequential, branch, jump, register jump) when the write-back stage strobes it.

Parameters:
- PC_RESET, 32'h0000_1000, PC value loaded on reset (word address).
- TIMEOUT, 16, max cycles waiting for MEM_READY before fault (used only with FETCH_TIMEOUT_EN).

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  synchronous, active-low reset.
- FETCH  in  1  one-cycle pulse from control unit in fetch state: start instruction read.
- PC_UPDATE  in  1  one-cycle strobe: load next PC selected by PC_SEL.
- PC_SEL  in  2  00 PC+1, 01 branch, 10 jump, 11 register.
- IMM  in  16  branch offset, signed, in words.
- JADDR  in  26  jump target field.
- REG_TARGET  in  32  register value for jr.
- MEM_DATA  in  32  read data from instruction memory.
- MEM_READY  in  1  memory completion; MEM_DATA valid in same cycle.
- MEM_READ  out  1  memory read request, held until MEM_READY.
- MEM_ADDR  out  26  word address = PC[25:0] captured at request.
- INSTRUCTION  out  32  instruction register.
- PC  out  32  current PC.
- PC_PLUS1  out  32  PC + 1, combinational.
- BUSY  out  1  high while a read is outstanding.
- FETCH_DONE  out  1  one-cycle pulse when INSTRUCTION updated.
- FAULT  out  1  sticky fetch timeout flag (tied 0 without FETCH_TIMEOUT_EN).

Behaviour:
- Reset (RST=0 at edge): PC=PC_RESET, INSTRUCTION=0, MEM_READ=0, MEM_ADDR=0, BUSY=0, FETCH_DONE=0, FAULT=0, state IDLE, pending flags cleared.
- Reset applies mid-read as well. The outstanding request is dropped, and a late MEM_READY after reset is ignored.
- FSM states:
  - IDLE -> REQ on FETCH.
  - REQ -> WAIT unconditionally. This cycle drives MEM_READ=1, MEM_ADDR=PC[25:0], BUSY=1.
  - WAIT -> IDLE on MEM_READY=1. On that edge: INSTRUCTION<=MEM_DATA, MEM_READ<=0, BUSY<=0, FETCH_DONE=1 for exactly one cycle.
- MEM_ADDR and MEM_READ stay stable throughout WAIT.
- Minimum latency: FETCH at edge n gives MEM_READ high from edge n+1. If MEM_READY=1 in the first WAIT cycle, INSTRUCTION updates at edge n+2.
- FETCH while BUSY is ignored; no queueing.
- Next PC, taken on the edge where PC_UPDATE=1:
  - 00: PC+1.
  - 01: PC+1+sext32(IMM).
  - 10: {PC_PLUS1[31:26], JADDR}.
  - 11: REG_TARGET.
- All PC arithmetic is modulo 2^32; wrap from 32'hFFFF_FFFF to 0 is silent.
- PC_UPDATE while BUSY: the select and operands are latched into a pending register. They are applied on the edge that completes the read, so MEM_ADDR is never disturbed. A second PC_UPDATE before completion overwrites the pending one.
- PC_UPDATE and FETCH in the same cycle in IDLE: the PC updates at that edge, and the fetch is deferred one cycle so it reads the new PC (REQ one edge later).
- INSTRUCTION holds its value between fetches. PC changes never alter INSTRUCTION.

Optional Feature:
- Macro FETCH_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT. If MEM_READY has not arrived after TIMEOUT cycles, the read is abandoned.
  - On abandonment: INSTRUCTION<=32'h0 (NOP), FAULT<=1 (sticky until reset), FETCH_DONE pulses, state returns to IDLE, and MEM_READ drops.
  - MEM_READY in the same cycle as expiry wins: normal completion, no fault.
- Undefined: no counter, FAULT tied 0, and WAIT persists indefinitely.

Test Plan:
- Reset: RST=0 for 2 cycles, then 1 -> PC=32'h1000, INSTRUCTION=0, MEM_READ=0, BUSY=0.
- Zero-wait fetch: FETCH at cycle 0, MEM_READY=1 with MEM_DATA=32'h2001_0005 on the first WAIT cycle -> MEM_ADDR=26'h1000, INSTRUCTION=32'h2001_0005 after 2 edges, FETCH_DONE high 1 cycle.
- Wait states: MEM_READY delayed 5 cycles -> MEM_READ and MEM_ADDR stable for 5 cycles, BUSY high, second FETCH ignored, single FETCH_DONE.
- PC updates from PC=32'h1000:
  - PC_SEL=01, IMM=16'hFFFE -> PC=32'h0FFF.
  - PC_SEL=10, JADDR=26'h0002000 -> PC=32'h0000_2000.
  - PC_SEL=11, REG_TARGET=32'h1234 -> PC=32'h1234.
  - PC=32'hFFFF_FFFF with PC_SEL=00 -> PC=0.
- Deferred update: PC_UPDATE with PC_SEL=00 during WAIT -> MEM_ADDR unchanged; PC=32'h1001 on the completion edge. Simultaneous FETCH+PC_UPDATE in IDLE -> read address 26'h1001.
- Timeout (FETCH_TIMEOUT_EN, TIMEOUT=16): no MEM_READY -> after 16 WAIT cycles INSTRUCTION=0, FAULT=1, MEM_READ=0. Reset mid-WAIT -> IDLE, and a late MEM_READY leaves INSTRUCTION=0.

Source files
------------

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: owns the PC and instruction register, issues word reads to instruction memory.
// Optional read watchdog with sticky FAULT is enabled by defining FETCH_TIMEOUT_EN.
module inst_fetch_unit #(
    parameter logic [31:0] PC_RESET = 32'h0000_1000
`ifdef FETCH_TIMEOUT_EN
    , parameter int TIMEOUT = 16
`endif
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        fetch_i,
    input  logic        pc_update_i,
    input  logic [1:0]  pc_sel_i,
    input  logic [15:0] imm_i,
    input  logic [25:0] jaddr_i,
    input  logic [31:0] reg_target_i,
    input  logic [31:0] mem_data_i,
    input  logic        mem_ready_i,
    output logic        mem_read_o,
    output logic [25:0] mem_addr_o,
    output logic [31:0] instruction_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus1_o,
    output logic        busy_o,
    output logic        fetch_done_o,
    output logic        fault_o
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d, instr_q, instr_d;
    logic [25:0] memAddr_q, memAddr_d;
    logic        memRead_q, memRead_d, busy_q, busy_d, done_q, done_d;
    logic        deferred_q, deferred_d, pendValid_q, pendValid_d;
    logic [1:0]  pendSel_q, pendSel_d;
    logic [15:0] pendImm_q, pendImm_d;
    logic [25:0] pendJaddr_q, pendJaddr_d;
    logic [31:0] pendReg_q, pendReg_d;
    logic        issue, complete, abandon, expired;
    logic [31:0] pcPlus1;

    assign pcPlus1 = pc_q + 32'd1;

    function automatic logic [31:0] nextPc(input logic [1:0] sel, input logic [15:0] imm,
                                           input logic [25:0] jaddr, input logic [31:0] regT,
                                           input logic [31:0] plus1);
        case (sel)
            2'b00:   nextPc = plus1;
            2'b01:   nextPc = plus1 + {{16{imm[15]}}, imm};
            2'b10:   nextPc = {plus1[31:26], jaddr};
            default: nextPc = regT;
        endcase
    endfunction

`ifdef FETCH_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] timer_q, timer_d;
    logic          fault_q, fault_d;

    assign expired = (timer_q == TW'(TIMEOUT - 1));
    assign timer_d = (state_q == WAIT) ? timer_q + TW'(1) : '0;
    assign fault_d = fault_q | abandon;
    assign fault_o = fault_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            timer_q <= '0;
            fault_q <= 1'b0;
        end else begin
            timer_q <= timer_d;
            fault_q <= fault_d;
        end
    end
`else
    assign expired = 1'b0;
    assign fault_o = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            pc_q        <= PC_RESET;
            instr_q     <= '0;
            memAddr_q   <= '0;
            memRead_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            deferred_q  <= 1'b0;
            pendValid_q <= 1'b0;
            pendSel_q   <= '0;
            pendImm_q   <= '0;
            pendJaddr_q <= '0;
            pendReg_q   <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            memAddr_q   <= memAddr_d;
            memRead_q   <= memRead_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            deferred_q  <= deferred_d;
            pendValid_q <= pendValid_d;
            pendSel_q   <= pendSel_d;
            pendImm_q   <= pendImm_d;
            pendJaddr_q <= pendJaddr_d;
            pendReg_q   <= pendReg_d;
        end
    end

    // A fetch arriving with a PC update waits one cycle so it reads the updated PC.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (deferred_q || (fetch_i && !pc_update_i)) state_d = REQ;
            REQ:     state_d = WAIT;
            WAIT:    if (mem_ready_i || expired) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        issue    = (state_q == REQ);
        complete = (state_q == WAIT) && mem_ready_i;
        abandon  = (state_q == WAIT) && !mem_ready_i && expired;
    end

    always_comb begin
        pc_d        = pc_q;
        instr_d     = instr_q;
        memAddr_d   = memAddr_q;
        memRead_d   = memRead_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        deferred_d  = 1'b0;
        pendValid_d = pendValid_q;
        pendSel_d   = pendSel_q;
        pendImm_d   = pendImm_q;
        pendJaddr_d = pendJaddr_q;
        pendReg_d   = pendReg_q;

        if (issue) begin
            memRead_d = 1'b1;
            memAddr_d = pc_q[25:0];
            busy_d    = 1'b1;
        end
        if (complete || abandon) begin
            memRead_d = 1'b0;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            instr_d   = complete ? mem_data_i : 32'h0;
        end

        // While a read is in flight, PC updates park in the pending register until it ends.
        if (state_q == IDLE) begin
            if (pc_update_i)
                pc_d = nextPc(pc_sel_i, imm_i, jaddr_i, reg_target_i, pcPlus1);
            deferred_d = fetch_i && pc_update_i && !deferred_q;
        end else if (complete || abandon) begin
            if (pc_update_i)
                pc_d = nextPc(pc_sel_i, imm_i, jaddr_i, reg_target_i, pcPlus1);
            else if (pendValid_q)
                pc_d = nextPc(pendSel_q, pendImm_q, pendJaddr_q, pendReg_q, pcPlus1);
            pendValid_d = 1'b0;
        end else if (pc_update_i) begin
            pendValid_d = 1'b1;
            pendSel_d   = pc_sel_i;
            pendImm_d   = imm_i;
            pendJaddr_d = jaddr_i;
            pendReg_d   = reg_target_i;
        end
    end

    assign mem_read_o    = memRead_q;
    assign mem_addr_o    = memAddr_q;
    assign instruction_o = instr_q;
    assign pc_o          = pc_q;
    assign pc_plus1_o    = pcPlus1;
    assign busy_o        = busy_q;
    assign fetch_done_o  = done_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: scoreboarded fetches, table-driven PC updates, and
// hand-written reset/deferral/timeout sequences (timeout part active when FETCH_TIMEOUT_EN is defined).
module tb_inst_fetch_unit;

    logic        clk = 1'b0;
    logic        rstN, fetch, pcUpdate, memReady;
    logic [1:0]  pcSel;
    logic [15:0] imm;
    logic [25:0] jaddr;
    logic [31:0] regTarget, memData;
    logic        memRead, busy, fetchDone, fault;
    logic [25:0] memAddr;
    logic [31:0] instruction, pc, pcPlus1;

    int checks = 0;
    int errors = 0;
    logic [31:0] sb[$];

    typedef struct {
        logic [31:0] startPc;
        logic [1:0]  sel;
        logic [15:0] imm;
        logic [25:0] jaddr;
        logic [31:0] regT;
        logic [31:0] expPc;
    } pcVec_t;

    pcVec_t vecs[9];

    inst_fetch_unit dut (
        .clk_i        (clk),
        .rst_ni       (rstN),
        .fetch_i      (fetch),
        .pc_update_i  (pcUpdate),
        .pc_sel_i     (pcSel),
        .imm_i        (imm),
        .jaddr_i      (jaddr),
        .reg_target_i (regTarget),
        .mem_data_i   (memData),
        .mem_ready_i  (memReady),
        .mem_read_o   (memRead),
        .mem_addr_o   (memAddr),
        .instruction_o(instruction),
        .pc_o         (pc),
        .pc_plus1_o   (pcPlus1),
        .busy_o       (busy),
        .fetch_done_o (fetchDone),
        .fault_o      (fault)
    );

    always #5 clk = ~clk;

    // Watchdog so a stuck handshake can never hang the run.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Scoreboard: every completion pops the instruction expected for the oldest fetch.
    always @(negedge clk) begin
        if (rstN === 1'b1 && fetchDone === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("[TB] FAIL sbUnexpectedDone: got FETCH_DONE with instruction %h, expected none", instruction);
            end else begin
                logic [31:0] exp;
                exp = sb.pop_front();
                if (instruction !== exp) begin
                    errors++;
                    $display("[TB] FAIL sbInstruction: got %h expected %h", instruction, exp);
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setPc(input logic [31:0] value);
        pcUpdate  = 1'b1;
        pcSel     = 2'b11;
        regTarget = value;
        tick();
        pcUpdate  = 1'b0;
    endtask

    task automatic waitForRead(input string name, output int latency);
        latency = 0;
        while (memRead !== 1'b1 && latency < 8) begin
            tick();
            latency++;
        end
        checkOutput({name, "ReadSeen"}, {31'b0, memRead}, 32'd1);
    endtask

    // One full fetch: optional wait states and an optional stray FETCH while busy.
    task automatic applyStimulus(input int waitCycles, input logic [31:0] data,
                                 input logic [25:0] expAddr, input bit strayFetch);
        int lat;
        fetch = 1'b1;
        sb.push_back(data);
        tick();
        fetch = 1'b0;
        checkOutput("readNotYet", {31'b0, memRead}, 32'd0);
        waitForRead("fetch", lat);
        checkOutput("readLatency", lat, 32'd1);
        checkOutput("memAddr", {6'b0, memAddr}, {6'b0, expAddr});
        checkOutput("busyHigh", {31'b0, busy}, 32'd1);
        for (int k = 0; k < waitCycles; k++) begin
            if (strayFetch && k == 1) fetch = 1'b1;
            tick();
            fetch = 1'b0;
            checkOutput("waitRead", {31'b0, memRead}, 32'd1);
            checkOutput("waitAddr", {6'b0, memAddr}, {6'b0, expAddr});
            checkOutput("waitDone", {31'b0, fetchDone}, 32'd0);
        end
        memReady = 1'b1;
        memData  = data;
        tick();
        memReady = 1'b0;
        memData  = 32'hx;
        checkOutput("instruction", instruction, data);
        checkOutput("doneHigh", {31'b0, fetchDone}, 32'd1);
        checkOutput("readDropped", {31'b0, memRead}, 32'd0);
        checkOutput("busyDropped", {31'b0, busy}, 32'd0);
        tick();
        checkOutput("donePulse", {31'b0, fetchDone}, 32'd0);
        tick();
        checkOutput("noQueuedRead", {31'b0, memRead}, 32'd0);
    endtask

    initial begin
        int lat;
        vecs[0] = '{32'h0000_1000, 2'b01, 16'hFFFE, 26'h0,       32'h0,    32'h0000_0FFF};
        vecs[1] = '{32'h0000_1000, 2'b10, 16'h0,    26'h0002000, 32'h0,    32'h0000_2000};
        vecs[2] = '{32'h0000_1000, 2'b11, 16'h0,    26'h0,       32'h1234, 32'h0000_1234};
        vecs[3] = '{32'hFFFF_FFFF, 2'b00, 16'h0,    26'h0,       32'h0,    32'h0000_0000};
        vecs[4] = '{32'h0000_1000, 2'b00, 16'h0,    26'h0,       32'h0,    32'h0000_1001};
        vecs[5] = '{32'h0000_1000, 2'b01, 16'h0010, 26'h0,       32'h0,    32'h0000_1011};
        vecs[6] = '{32'h0000_1000, 2'b01, 16'h8000, 26'h0,       32'h0,    32'hFFFF_9001};
        vecs[7] = '{32'hFC00_0000, 2'b10, 16'h0,    26'h0000123, 32'h0,    32'hFC00_0123};
        vecs[8] = '{32'h7FFF_FFFF, 2'b01, 16'h7FFF, 26'h0,       32'h0,    32'h8000_7FFF};

        rstN = 1'b0; fetch = 1'b0; pcUpdate = 1'b0; memReady = 1'b0;
        pcSel = 2'b00; imm = '0; jaddr = '0; regTarget = '0; memData = '0;
        tick();
        tick();
        rstN = 1'b1;
        checkOutput("rstPc", pc, 32'h0000_1000);
        checkOutput("rstPcPlus1", pcPlus1, 32'h0000_1001);
        checkOutput("rstInstr", instruction, 32'h0);
        checkOutput("rstRead", {31'b0, memRead}, 32'd0);
        checkOutput("rstAddr", {6'b0, memAddr}, 32'd0);
        checkOutput("rstBusy", {31'b0, busy}, 32'd0);
        checkOutput("rstDone", {31'b0, fetchDone}, 32'd0);
        checkOutput("rstFault", {31'b0, fault}, 32'd0);

        $display("[TB] zero-wait and wait-state fetches");
        applyStimulus(0, 32'h2001_0005, 26'h1000, 1'b0);
        applyStimulus(5, 32'hAABB_CCDD, 26'h1000, 1'b1);
        checkOutput("pcUnchangedByFetch", pc, 32'h0000_1000);

        $display("[TB] table-driven PC updates");
        for (int i = 0; i < 9; i++) begin
            setPc(vecs[i].startPc);
            pcUpdate  = 1'b1;
            pcSel     = vecs[i].sel;
            imm       = vecs[i].imm;
            jaddr     = vecs[i].jaddr;
            regTarget = vecs[i].regT;
            tick();
            pcUpdate  = 1'b0;
            checkOutput($sformatf("pcVec%0d", i), pc, vecs[i].expPc);
            checkOutput($sformatf("pcPlus1Vec%0d", i), pcPlus1, vecs[i].expPc + 32'd1);
            checkOutput($sformatf("instrHeldVec%0d", i), instruction, 32'hAABB_CCDD);
        end
        imm = '0; jaddr = '0;

        $display("[TB] PC update deferred during WAIT, second update overwrites first");
        setPc(32'h0000_1000);
        fetch = 1'b1;
        sb.push_back(32'h1111_2222);
        tick();
        fetch = 1'b0;
        waitForRead("deferred", lat);
        pcUpdate = 1'b1; pcSel = 2'b11; regTarget = 32'h0000_7777;
        tick();
        pcSel = 2'b00;
        tick();
        pcUpdate = 1'b0;
        checkOutput("deferPcHeld", pc, 32'h0000_1000);
        checkOutput("deferAddrHeld", {6'b0, memAddr}, 32'h0000_1000);
        memReady = 1'b1; memData = 32'h1111_2222;
        tick();
        memReady = 1'b0;
        checkOutput("deferPcApplied", pc, 32'h0000_1001);
        checkOutput("deferInstr", instruction, 32'h1111_2222);
        tick();

        $display("[TB] simultaneous FETCH and PC_UPDATE in IDLE");
        setPc(32'h0000_1000);
        fetch = 1'b1; pcUpdate = 1'b1; pcSel = 2'b00;
        sb.push_back(32'h3333_4444);
        tick();
        fetch = 1'b0; pcUpdate = 1'b0;
        checkOutput("simulPc", pc, 32'h0000_1001);
        checkOutput("simulNoReadYet", {31'b0, memRead}, 32'd0);
        waitForRead("simul", lat);
        checkOutput("simulLatency", lat, 32'd2);
        checkOutput("simulAddr", {6'b0, memAddr}, 32'h0000_1001);
        memReady = 1'b1; memData = 32'h3333_4444;
        tick();
        memReady = 1'b0;
        checkOutput("simulInstr", instruction, 32'h3333_4444);
        tick();

        $display("[TB] reset mid-read, late MEM_READY ignored");
        fetch = 1'b1;
        sb.push_back(32'h5555_6666);
        tick();
        fetch = 1'b0;
        waitForRead("rstMid", lat);
`ifndef FETCH_TIMEOUT_EN
        for (int k = 0; k < 20; k++) tick();
        checkOutput("waitIndefinite", {31'b0, memRead}, 32'd1);
        checkOutput("noFaultWithoutTimeout", {31'b0, fault}, 32'd0);
`endif
        rstN = 1'b0;
        sb.delete();
        tick();
        rstN = 1'b1;
        checkOutput("rstMidRead", {31'b0, memRead}, 32'd0);
        checkOutput("rstMidBusy", {31'b0, busy}, 32'd0);
        checkOutput("rstMidInstr", instruction, 32'h0);
        checkOutput("rstMidPc", pc, 32'h0000_1000);
        memReady = 1'b1; memData = 32'hDEAD_BEEF;
        tick();
        memReady = 1'b0;
        checkOutput("lateReadyDone", {31'b0, fetchDone}, 32'd0);
        tick();
        checkOutput("lateReadyInstr", instruction, 32'h0);
        checkOutput("lateReadyRead", {31'b0, memRead}, 32'd0);

`ifdef FETCH_TIMEOUT_EN
        $display("[TB] MEM_READY on the expiry cycle wins");
        fetch = 1'b1;
        sb.push_back(32'h7777_8888);
        tick();
        fetch = 1'b0;
        waitForRead("expiryWin", lat);
        for (int k = 0; k < 15; k++) tick();
        memReady = 1'b1; memData = 32'h7777_8888;
        tick();
        memReady = 1'b0;
        checkOutput("expiryWinInstr", instruction, 32'h7777_8888);
        checkOutput("expiryWinFault", {31'b0, fault}, 32'd0);
        tick();

        $display("[TB] fetch timeout");
        fetch = 1'b1;
        sb.push_back(32'h0);
        tick();
        fetch = 1'b0;
        waitForRead("timeout", lat);
        for (int k = 0; k < 15; k++) tick();
        checkOutput("timeoutStillWaiting", {31'b0, memRead}, 32'd1);
        checkOutput("timeoutNoFaultYet", {31'b0, fault}, 32'd0);
        tick();
        checkOutput("timeoutRead", {31'b0, memRead}, 32'd0);
        checkOutput("timeoutInstr", instruction, 32'h0);
        checkOutput("timeoutFault", {31'b0, fault}, 32'd1);
        checkOutput("timeoutDone", {31'b0, fetchDone}, 32'd1);
        tick();
        applyStimulus(2, 32'h9999_AAAA, 26'h1000, 1'b0);
        checkOutput("faultSticky", {31'b0, fault}, 32'd1);
        rstN = 1'b0;
        tick();
        rstN = 1'b1;
        checkOutput("faultClearedByReset", {31'b0, fault}, 32'd0);
`endif

        tick();
        checkOutput("sbDrained", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
